// File: rtl/read_symbol3_pkg.sv
// Shared definitions for the X-symbol reader: FSM states, default symbol colour
// and the 32-step scan pattern that the drawing block also uses.
package read_symbol3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sym3_state_t;

    localparam logic [2:0] SYM_COLOUR_DEF = 3'b101;
    localparam int         PATTERN_LEN    = 32;

    typedef struct packed {
        logic [4:0] dx;
        logic [4:0] dy;
    } sym3_offset_t;

    // Steps 0..15 walk the main diagonal, steps 16..31 walk the anti-diagonal.
    function automatic sym3_offset_t sym3_offset(input logic [4:0] k);
        sym3_offset_t o;
        if (k[4] == 1'b0) begin
            o.dx = k;
            o.dy = k;
        end else begin
            o.dx = 5'd31 - k;
            o.dy = {1'b0, k[3:0]};
        end
        return o;
    endfunction

endpackage

// File: rtl/read_symbol3_pattern_gen.sv
// Step counter and offset generator for the symbol scan.
module sym3_pattern_gen
    import read_symbol3_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       clr,
    output logic [4:0] dx,
    output logic [4:0] dy,
    output logic       last
);

    logic [4:0]   step;
    sym3_offset_t off;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step <= '0;
        end else if (clr) begin
            step <= '0;
        end else if (en) begin
            step <= step + 5'd1;
        end
    end

    assign off  = sym3_offset(step);
    assign dx   = off.dx;
    assign dy   = off.dy;
    assign last = (step == 5'(PATTERN_LEN - 1));

endmodule

// File: rtl/read_symbol3.sv
// Scans the 32 pixels of an X-shaped cell from pixel memory and counts how many
// carry the symbol colour.
module read_symbol3
    import read_symbol3_pkg::*;
#(
    parameter logic [2:0] SYM_COLOUR   = SYM_COLOUR_DEF,
    parameter int         MATCH_THRESH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [6:0] y,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    output logic       rd_en,
    input  logic [2:0] rd_colour,
    output logic       busy,
    output logic       done,
    output logic [5:0] match_count,
    output logic       is_x,
    output logic [1:0] dbg_state
);

    // Handshake: start is a request taken only while idle (busy=0); busy stays
    // high through the done pulse, and requests arriving while busy are dropped.

    sym3_state_t state_q, state_d;
    logic        start_acc;
    logic        gen_en;
    logic        gen_clr;
    logic        last;
    logic [4:0]  dx, dy;
    logic [7:0]  x_lat;
    logic [6:0]  y_lat;
    logic        rd_pend;
    logic [5:0]  mc_q;

    sym3_pattern_gen u_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (gen_en),
        .clr     (gen_clr),
        .dx      (dx),
        .dy      (dy),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ISSUE;
            ST_ISSUE: if (last)  state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_acc = 1'b0;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        gen_en    = 1'b0;
        gen_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_acc = start;
                gen_clr   = start;
            end
            ST_ISSUE: begin
                rd_en  = 1'b1;
                busy   = 1'b1;
                gen_en = 1'b1;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // rd_pend marks the cycle in which the previous read's data is on rd_colour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_lat   <= '0;
            y_lat   <= '0;
            rd_pend <= 1'b0;
            mc_q    <= '0;
        end else begin
            rd_pend <= rd_en;
            if (start_acc) begin
                x_lat <= x;
                y_lat <= y;
                mc_q  <= '0;
            end else if (rd_pend && (rd_colour == SYM_COLOUR)) begin
                mc_q <= mc_q + 6'd1;
            end
        end
    end

    assign rd_x        = rd_en ? (x_lat + {3'b000, dx}) : x_lat;
    assign rd_y        = rd_en ? (y_lat + {2'b00, dy}) : y_lat;
    assign match_count = mc_q;
    assign is_x        = (int'({26'd0, mc_q}) >= MATCH_THRESH);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_read_symbol3.sv
// Directed bench for read_symbol3 with a behavioural pixel memory.
module tb_read_symbol3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] x;
    logic [6:0] y;

    logic [7:0] rd_x, rd_x2;
    logic [6:0] rd_y, rd_y2;
    logic       rd_en, rd_en2;
    logic [2:0] rd_colour = 3'b000, rd_colour2 = 3'b000;
    logic       busy, busy2, done, done2, is_x, is_x2;
    logic [5:0] match_count, match_count2;
    logic [1:0] dbg_state, dbg_state2;

    int total = 0;
    int bad   = 0;

    logic [2:0] mem [256][128];

    // scan record
    int         n_rd, n_done, n_done2, done_cyc, first_rd_cyc, last_rd_cyc;
    logic [7:0] ax [32];
    logic [6:0] ay [32];
    logic       busy34, busy35, isx_end, isx2_end;
    logic [5:0] mc_end;
    logic [7:0] hold_x;
    logic [6:0] hold_y;

    always #5 clk = ~clk;

    read_symbol3 dut (
        .clk(clk), .reset_n(reset_n), .start(start), .x(x), .y(y),
        .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en), .rd_colour(rd_colour),
        .busy(busy), .done(done), .match_count(match_count), .is_x(is_x),
        .dbg_state(dbg_state)
    );

    read_symbol3 #(.MATCH_THRESH(31)) dut31 (
        .clk(clk), .reset_n(reset_n), .start(start), .x(x), .y(y),
        .rd_x(rd_x2), .rd_y(rd_y2), .rd_en(rd_en2), .rd_colour(rd_colour2),
        .busy(busy2), .done(done2), .match_count(match_count2), .is_x(is_x2),
        .dbg_state(dbg_state2)
    );

    always @(posedge clk) begin
        if (rd_en)  rd_colour  <= mem[rd_x][rd_y];
        if (rd_en2) rd_colour2 <= mem[rd_x2][rd_y2];
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 128; j++)
                mem[i][j] = 3'b000;
    endtask

    task automatic draw_x(input logic [7:0] ox, input logic [6:0] oy);
        logic [7:0] px;
        logic [6:0] py;
        for (int k = 0; k < 32; k++) begin
            if (k < 16) begin
                px = ox + 8'(k);
                py = oy + 7'(k);
            end else begin
                px = ox + 8'(31 - k);
                py = oy + 7'(k - 16);
            end
            mem[px][py] = 3'b101;
        end
    endtask

    // Cycle 0 is the cycle start is high; start_mask bit c drives start in cycle c.
    task automatic do_scan(input logic [7:0] ox, input logic [6:0] oy, input logic [63:0] start_mask);
        n_rd = 0; n_done = 0; n_done2 = 0; done_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1;
        busy34 = 1'b0; busy35 = 1'b1;
        @(negedge clk);
        x = ox; y = oy; start = start_mask[0];
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                start = start_mask[c];
            end
            if (rd_en) begin
                if (n_rd < 32) begin
                    ax[n_rd] = rd_x;
                    ay[n_rd] = rd_y;
                end
                if (first_rd_cyc < 0) first_rd_cyc = c;
                last_rd_cyc = c;
                n_rd++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done2) n_done2++;
            if (c == 34) busy34 = busy;
            if (c == 35) busy35 = busy;
        end
        start    = 1'b0;
        mc_end   = match_count;
        isx_end  = is_x;
        isx2_end = is_x2;
        hold_x   = rd_x;
        hold_y   = rd_y;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rd_x, rd_y, rd_en, busy, done, match_count, is_x} !== 24'd0) begin
            bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d en=%b busy=%b done=%b mc=%0d is_x=%b, want all 0",
                     rd_x, rd_y, rd_en, busy, done, match_count, is_x);
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_x();
        int addr_err;
        logic [7:0] ex;
        logic [6:0] ey;
        clear_mem();
        draw_x(8'd40, 7'd20);
        do_scan(8'd40, 7'd20, 64'h1);
        addr_err = 0;
        for (int k = 0; k < 32; k++) begin
            ex = (k < 16) ? 8'(40 + k) : 8'(40 + 31 - k);
            ey = (k < 16) ? 7'(20 + k) : 7'(20 + k - 16);
            if (ax[k] !== ex || ay[k] !== ey) addr_err++;
        end
        total++;
        if (n_rd !== 32) begin bad++; $display("FAIL full_rd_count: got %0d want 32", n_rd); end
        total++;
        if (first_rd_cyc !== 1 || last_rd_cyc !== 32) begin
            bad++; $display("FAIL full_rd_window: got %0d..%0d want 1..32", first_rd_cyc, last_rd_cyc);
        end
        total++;
        if (ax[0] !== 8'd40 || ay[0] !== 7'd20) begin
            bad++; $display("FAIL full_first_addr: got (%0d,%0d) want (40,20)", ax[0], ay[0]);
        end
        total++;
        if (ax[16] !== 8'd55 || ay[16] !== 7'd20) begin
            bad++; $display("FAIL full_17th_addr: got (%0d,%0d) want (55,20)", ax[16], ay[16]);
        end
        total++;
        if (ax[31] !== 8'd40 || ay[31] !== 7'd35) begin
            bad++; $display("FAIL full_last_addr: got (%0d,%0d) want (40,35)", ax[31], ay[31]);
        end
        total++;
        if (addr_err !== 0) begin bad++; $display("FAIL full_all_addr: got %0d wrong want 0", addr_err); end
        total++;
        if (done_cyc !== 34 || n_done !== 1) begin
            bad++; $display("FAIL full_done: got cycle %0d count %0d want cycle 34 count 1", done_cyc, n_done);
        end
        total++;
        if (busy34 !== 1'b1 || busy35 !== 1'b0) begin
            bad++; $display("FAIL full_busy: got c34=%b c35=%b want 1,0", busy34, busy35);
        end
        total++;
        if (mc_end !== 6'd32 || isx_end !== 1'b1) begin
            bad++; $display("FAIL full_result: got mc=%0d is_x=%b want 32,1", mc_end, isx_end);
        end
        total++;
        if (hold_x !== 8'd40 || hold_y !== 7'd20) begin
            bad++; $display("FAIL full_idle_addr: got (%0d,%0d) want (40,20)", hold_x, hold_y);
        end
    endtask

    task automatic test_blank();
        clear_mem();
        do_scan(8'd0, 7'd0, 64'h1);
        total++;
        if (mc_end !== 6'd0 || isx_end !== 1'b0) begin
            bad++; $display("FAIL blank_result: got mc=%0d is_x=%b want 0,0", mc_end, isx_end);
        end
        total++;
        if (done_cyc !== 34) begin bad++; $display("FAIL blank_done: got %0d want 34", done_cyc); end
    endtask

    task automatic test_missing_pixel();
        clear_mem();
        draw_x(8'd40, 7'd20);
        mem[47][27] = 3'b000;
        do_scan(8'd40, 7'd20, 64'h1);
        total++;
        if (mc_end !== 6'd31 || isx_end !== 1'b0) begin
            bad++; $display("FAIL missing_result: got mc=%0d is_x=%b want 31,0", mc_end, isx_end);
        end
        total++;
        if (isx2_end !== 1'b1 || n_done2 !== 1) begin
            bad++; $display("FAIL missing_thresh31: got is_x=%b done=%0d want 1,1", isx2_end, n_done2);
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        do_scan(8'd250, 7'd120, 64'h1);
        total++;
        if (ax[6] !== 8'd0 || ay[6] !== 7'd126) begin
            bad++; $display("FAIL wrap_step6: got (%0d,%0d) want (0,126)", ax[6], ay[6]);
        end
        total++;
        if (ax[8] !== 8'd2 || ay[8] !== 7'd0) begin
            bad++; $display("FAIL wrap_step8: got (%0d,%0d) want (2,0)", ax[8], ay[8]);
        end
        total++;
        if (done_cyc !== 34 || n_rd !== 32) begin
            bad++; $display("FAIL wrap_done: got cycle %0d reads %0d want 34,32", done_cyc, n_rd);
        end
    endtask

    task automatic test_start_ignored();
        clear_mem();
        draw_x(8'd40, 7'd20);
        do_scan(8'd40, 7'd20, (64'h1 | (64'h1 << 5) | (64'h1 << 20)));
        total++;
        if (n_rd !== 32 || n_done !== 1) begin
            bad++; $display("FAIL ignore_start: got reads=%0d dones=%0d want 32,1", n_rd, n_done);
        end
        total++;
        if (done_cyc !== 34 || mc_end !== 6'd32) begin
            bad++; $display("FAIL ignore_result: got cycle %0d mc=%0d want 34,32", done_cyc, mc_end);
        end
    endtask

    task automatic test_reset_mid_scan();
        clear_mem();
        draw_x(8'd40, 7'd20);
        @(negedge clk);
        x = 8'd40; y = 7'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        total++;
        if (match_count !== 6'd8 || busy !== 1'b1) begin
            bad++; $display("FAIL midscan_progress: got mc=%0d busy=%b want 8,1", match_count, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({rd_x, rd_y, rd_en, busy, done, match_count, is_x} !== 24'd0) begin
            bad++;
            $display("FAIL midscan_async_reset: got x=%0d y=%0d en=%b busy=%b done=%b mc=%0d is_x=%b, want all 0",
                     rd_x, rd_y, rd_en, busy, done, match_count, is_x);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rd_en !== 1'b0 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL midscan_held: got en=%b state=%0d want 0,0", rd_en, dbg_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        do_scan(8'd40, 7'd20, 64'h1);
        total++;
        if (done_cyc !== 34 || n_rd !== 32 || first_rd_cyc !== 1) begin
            bad++; $display("FAIL after_reset_timing: got done=%0d reads=%0d first=%0d want 34,32,1",
                            done_cyc, n_rd, first_rd_cyc);
        end
        total++;
        if (mc_end !== 6'd32 || isx_end !== 1'b1) begin
            bad++; $display("FAIL after_reset_result: got mc=%0d is_x=%b want 32,1", mc_end, isx_end);
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_full_x();
        test_blank();
        test_missing_pixel();
        test_wrap();
        test_start_ignored();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/read_symbol3.md
READ_SYMBOL3 -- requirements
Module: read_symbol3

Interface
REQ-001 Parameter SYM_COLOUR, default 3'b101, is the colour counted as a symbol pixel.
REQ-002 Parameter MATCH_THRESH, default 32, is the minimum match count that reports an X.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 start  input  1  is the request to scan one cell; sampled only in IDLE.
REQ-006 x  input  8  is the cell origin column, latched when start is accepted.
REQ-007 y  input  7  is the cell origin row, latched when start is accepted.
REQ-008 rd_x  output  8  is the pixel-memory read column.
REQ-009 rd_y  output  7  is the pixel-memory read row.
REQ-010 rd_en  output  1  is the read strobe, one pixel per cycle.
REQ-011 rd_colour  input  3  is the read data, valid exactly one cycle after rd_en.
REQ-012 busy  output  1  is high from start acceptance until done, inclusive.
REQ-013 done  output  1  is a one-cycle pulse marking valid results.
REQ-014 match_count  output  6  is the number of scanned pixels equal to SYM_COLOUR (0..32).
REQ-015 is_x  output  1  is high when match_count >= MATCH_THRESH.

Function
REQ-016 The scan pattern SHALL be 32 steps k=0..31: k<16 gives offset (k,k); k>=16 gives offset (31-k, k-16).
REQ-017 The read address SHALL be rd_x = x_lat + dx, truncated to 8 bits, and rd_y = y_lat + dy, truncated to 7 bits; wrap-around is legal and unflagged.
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-019 IDLE->ISSUE SHALL occur on start=1; start is ignored in all other states.
REQ-020 ISSUE SHALL last exactly 32 cycles with rd_en=1 and step k incrementing by 1 each cycle from 0.
REQ-021 ISSUE->DRAIN SHALL occur after step 31; DRAIN SHALL last 1 cycle with rd_en=0.
REQ-022 DRAIN->DONE->IDLE SHALL occur unconditionally; done=1 only in DONE.
REQ-023 With start accepted in cycle 0, rd_en SHALL be high in cycles 1..32 and done high in cycle 34.
REQ-024 rd_colour SHALL be compared in the cycle after each rd_en cycle, 32 compares total; match_count SHALL be cleared on start acceptance.
REQ-025 match_count and is_x SHALL hold their final values from DONE until the next start is accepted.
REQ-026 rd_x and rd_y SHALL hold the origin value whenever rd_en=0.

Reset
REQ-027 Asserting reset_n=0 at any time, including mid-scan, SHALL force IDLE immediately and discard any in-flight read.
REQ-028 During reset, rd_x, rd_y, rd_en, busy, done, match_count and is_x SHALL all be 0.
REQ-029 After reset is released, the first start SHALL behave exactly as REQ-023.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the SYM_COLOUR default, and the 32-entry offset pattern so that the drawing block and this reader share one definition.
REQ-031 The step counter plus offset generator SHALL be one sub-module, sym3_pattern_gen, containing a 5-bit counter, an enable, a clear and a last flag.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Memory holds a full X of 3'b101 at (40,20); start -> 32 reads, first (40,20), 17th (55,20), last (40,35); done in cycle 34; match_count=32, is_x=1.
- Blank memory (all 3'b000), start at (0,0) -> match_count=0, is_x=0, done in cycle 34.
- X with pixel (47,27) set to 3'b000 -> match_count=31, is_x=0; rerun with MATCH_THRESH=31 -> is_x=1.
- Origin (250,120) -> reads wrap: step 6 is at (0,126), step 8 at (2,0); no hang.
- Start pulsed at cycles 5 and 20 of a scan -> both ignored; exactly 32 rd_en cycles and one done.
- reset_n pulled low at cycle 10 -> all outputs 0 asynchronously; after release, a new start completes normally.
